// File: rtl/quad_decoder_pkg.sv
// Shared mode constants, Gray transition codes and decode helpers for the quadrature decoder.
package quad_decoder_pkg;

   localparam logic [1:0] QD_MODE_X1 = 2'd0;
   localparam logic [1:0] QD_MODE_X2 = 2'd1;
   localparam logic [1:0] QD_MODE_X4 = 2'd2;

   localparam int unsigned QD_INIT_CYCLES = 4;

   // Transition codes are {prev_a, prev_b, cur_a, cur_b}
   localparam logic [3:0] QD_UP_00_10 = 4'b0010;
   localparam logic [3:0] QD_UP_10_11 = 4'b1011;
   localparam logic [3:0] QD_UP_11_01 = 4'b1101;
   localparam logic [3:0] QD_UP_01_00 = 4'b0100;
   localparam logic [3:0] QD_DN_00_01 = 4'b0001;
   localparam logic [3:0] QD_DN_01_11 = 4'b0111;
   localparam logic [3:0] QD_DN_11_10 = 4'b1110;
   localparam logic [3:0] QD_DN_10_00 = 4'b1000;

   typedef enum logic [1:0] {
      QD_EV_NONE    = 2'd0,
      QD_EV_UP      = 2'd1,
      QD_EV_DOWN    = 2'd2,
      QD_EV_ILLEGAL = 2'd3
   } qd_event_e;

   function automatic qd_event_e qd_classify(input logic [3:0] code);
      qd_event_e ev;
      case (code)
         QD_UP_00_10, QD_UP_10_11, QD_UP_11_01, QD_UP_01_00: ev = QD_EV_UP;
         QD_DN_00_01, QD_DN_01_11, QD_DN_11_10, QD_DN_10_00: ev = QD_EV_DOWN;
         4'b0011, 4'b0110, 4'b1001, 4'b1100:                 ev = QD_EV_ILLEGAL;
         default:                                             ev = QD_EV_NONE;
      endcase
      return ev;
   endfunction

   // Whether a legal transition produces a count event in the given resolution
   function automatic logic qd_qualify(input logic [1:0] mode, input logic [3:0] code);
      logic q;
      case (mode)
         QD_MODE_X1: q = (code == QD_UP_00_10) || (code == QD_DN_10_00);
         QD_MODE_X2: q = (code == QD_UP_00_10) || (code == QD_UP_11_01) ||
                         (code == QD_DN_10_00) || (code == QD_DN_01_11);
         default:    q = (qd_classify(code) == QD_EV_UP) || (qd_classify(code) == QD_EV_DOWN);
      endcase
      return q;
   endfunction

endpackage

// File: rtl/quad_decoder_debounce.sv
// Two-flop synchroniser followed by a counting debouncer; init_i bypasses the debounce delay.
module quad_decoder_debounce #(
   parameter int unsigned N = 14
) (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   input  logic init_i,
   output logic deb_o
);

   logic [1:0]   sync_q;
   logic         deb_q, deb_d;
   logic [N-1:0] dbc_q, dbc_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         deb_q  <= 1'b0;
         dbc_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], pin_i};
         deb_q  <= deb_d;
         dbc_q  <= dbc_d;
      end
   end

   // Counter only runs while the synchronised pin disagrees with the debounced value
   always_comb begin
      deb_d = deb_q;
      dbc_d = '0;
      if (init_i) begin
         deb_d = sync_q[1];
      end else if (sync_q[1] != deb_q) begin
         if (dbc_q == '1) deb_d = sync_q[1];
         else             dbc_d = dbc_q + N'(1);
      end
   end

   assign deb_o = deb_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: debounced A/B, x1/x2/x4 decode, wrap/saturate position count, sticky error.
module quad_decoder
   import quad_decoder_pkg::*;
#(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned DEBOUNCE_N = 14,
   parameter bit          WRAP       = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic [1:0]       mode,
   input  logic             clr,
   input  logic             err_clr,
   output logic [CNT_W-1:0] cnt,
   output logic             step,
   output logic             dir,
   output logic             err
);

   localparam int unsigned INIT_W = $clog2(QD_INIT_CYCLES + 1);

   logic [INIT_W-1:0] init_q, init_d;
   logic              init_busy;
   logic              deb_a, deb_b;
   logic [1:0]        prev_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              step_q, step_d;
   logic              dir_q, dir_d;
   logic              err_q, err_d;
   logic [3:0]        code;
   qd_event_e         ev;
   logic              qual;

   assign init_busy = (init_q != INIT_W'(QD_INIT_CYCLES));

   quad_decoder_debounce #(.N(DEBOUNCE_N)) u_deb_a (
      .clk    (clk),
      .rst    (rst),
      .pin_i  (a),
      .init_i (init_busy),
      .deb_o  (deb_a)
   );

   quad_decoder_debounce #(.N(DEBOUNCE_N)) u_deb_b (
      .clk    (clk),
      .rst    (rst),
      .pin_i  (b),
      .init_i (init_busy),
      .deb_o  (deb_b)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         init_q <= '0;
         prev_q <= 2'b00;
         cnt_q  <= '0;
         step_q <= 1'b0;
         dir_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         init_q <= init_d;
         prev_q <= {deb_a, deb_b};
         cnt_q  <= cnt_d;
         step_q <= step_d;
         dir_q  <= dir_d;
         err_q  <= err_d;
      end
   end

   assign code = {prev_q, deb_a, deb_b};
   assign ev   = qd_classify(code);
   assign qual = qd_qualify(mode, code);

   // Decode and count; suppressed until the INIT window has settled prev onto the pins
   always_comb begin
      init_d = init_busy ? init_q + INIT_W'(1) : init_q;
      cnt_d  = cnt_q;
      step_d = 1'b0;
      dir_d  = dir_q;
      err_d  = err_q & ~err_clr;
      if (!init_busy) begin
         if (ev == QD_EV_ILLEGAL) begin
            err_d = 1'b1;
         end else if (qual) begin
            step_d = 1'b1;
            dir_d  = (ev == QD_EV_UP);
            if (ev == QD_EV_UP) begin
               if (WRAP || cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else begin
               if (WRAP || cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
         end
      end
      if (clr) cnt_d = '0;
   end

   assign cnt  = cnt_q;
   assign step = step_q;
   assign dir  = dir_q;
   assign err  = err_q;

endmodule
